// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the fetch/decode hazard and interrupt controller.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [2:0] {
        S_NORMAL    = 3'd0,
        S_HALT      = 3'd1,
        S_INTERRUPT = 3'd2,
        S_STALL_F   = 3'd3,
        S_STALL_D   = 3'd4,
        S_RETURN    = 3'd5
    } state_t;

    localparam logic [2:0] PC_HOLD     = 3'b000;
    localparam logic [2:0] PC_INC      = 3'b001;
    localparam logic [2:0] PC_LOAD_INT = 3'b010;

    localparam logic [31:0] INT_OPCODE_DEF = 32'h0000_0042;

endpackage

// File: rtl/pipeline_hazard_ctrl_irq_arbiter.sv
// Fixed-priority interrupt arbiter: lowest unmasked pending index wins.
module irq_arbiter #(
    parameter int PC_WIDTH   = 14,
    parameter int NUM_IRQ    = 4,
    parameter int VEC_STRIDE = 4
) (
    input  logic [NUM_IRQ-1:0]  pending,
    input  logic [NUM_IRQ-1:0]  mask,
    input  logic [PC_WIDTH-1:0] base,
    output logic                valid,
    output logic [NUM_IRQ-1:0]  grant,
    output logic [PC_WIDTH-1:0] vec
);

    logic [NUM_IRQ-1:0] req;
    logic [3:0]         idx;

    assign req = pending & ~mask;

    // Scan downward so the lowest requesting index is the last one kept.
    always_comb begin
        valid = 1'b0;
        grant = '0;
        idx   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid    = 1'b1;
                grant    = '0;
                grant[i] = 1'b1;
                idx      = 4'(i);
            end
        end
    end

    assign vec = PC_WIDTH'(32'(base) + 32'(idx) * 32'(VEC_STRIDE));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Front-end hazard controller: arbitrates return, halt, stalls and
// latched prioritised interrupts into stall / PC-load / inject controls.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int PC_WIDTH   = 14,
    parameter int INST_WIDTH = 32,
    parameter int NUM_IRQ    = 4,
    parameter int VEC_STRIDE = 4,
    parameter int RET_DRAIN  = 4,
    parameter logic [INST_WIDTH-1:0] INT_OPCODE = INST_WIDTH'(INT_OPCODE_DEF)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  return_req,
    input  logic                  halt,
    input  logic                  fetch_stl_req,
    input  logic                  dec_stl_req,
    input  logic [NUM_IRQ-1:0]    irq,
    input  logic [NUM_IRQ-1:0]    irq_mask,
    input  logic [PC_WIDTH-1:0]   irq_vector_base,
    output logic                  stall_fetch,
    output logic                  stall_decode,
    output logic [2:0]            prog_cntr_load_sel,
    output logic                  inst_word_sel,
    output logic [INST_WIDTH-1:0] new_inst_word,
    output logic [PC_WIDTH-1:0]   prog_cntr_int_addr,
    output logic [NUM_IRQ-1:0]    irq_ack,
    output logic                  in_service,
    output logic [2:0]            state
);

    localparam int SH = INST_WIDTH - PC_WIDTH;

    state_t              st;
    logic [NUM_IRQ-1:0]  pending;
    logic [NUM_IRQ-1:0]  irq_q;
    logic [NUM_IRQ-1:0]  rise;
    logic [NUM_IRQ-1:0]  grant;
    logic [NUM_IRQ-1:0]  ack_nxt;
    logic                valid;
    logic                elig;
    logic                any_req;
    logic                take;
    logic [PC_WIDTH-1:0] vec;
    logic [INST_WIDTH-1:0] int_word;
    logic [3:0]          drain;

    irq_arbiter #(
        .PC_WIDTH  (PC_WIDTH),
        .NUM_IRQ   (NUM_IRQ),
        .VEC_STRIDE(VEC_STRIDE)
    ) u_arb (
        .pending(pending),
        .mask   (irq_mask),
        .base   (irq_vector_base),
        .valid  (valid),
        .grant  (grant),
        .vec    (vec)
    );

    assign elig     = valid & ~in_service;
    assign rise     = irq & ~irq_q;
    assign any_req  = return_req | halt | fetch_stl_req | dec_stl_req;
    assign int_word = INT_OPCODE | {vec, {SH{1'b0}}};
    assign ack_nxt  = take ? grant : '0;
    assign state    = st;

    // Decoded requests outrank interrupts in NORMAL; pending is kept.
    always_comb begin
        take = 1'b0;
        case (st)
            S_NORMAL:                    take = elig & ~any_req;
            S_HALT, S_STALL_F, S_STALL_D: take = elig;
            default:                     take = 1'b0;
        endcase
    end

    always_ff @(negedge clock) begin
        if (!reset_n) begin
            st                 <= S_NORMAL;
            stall_fetch        <= 1'b0;
            stall_decode       <= 1'b0;
            prog_cntr_load_sel <= PC_INC;
            inst_word_sel      <= 1'b0;
            new_inst_word      <= '0;
            prog_cntr_int_addr <= '0;
            irq_ack            <= '0;
            in_service         <= 1'b0;
            pending            <= '0;
            irq_q              <= '0;
            drain              <= '0;
        end else begin
            irq_q   <= irq;
            pending <= (pending & ~ack_nxt) | rise;
            irq_ack <= ack_nxt;

            st                 <= S_NORMAL;
            stall_fetch        <= 1'b0;
            stall_decode       <= 1'b0;
            prog_cntr_load_sel <= PC_INC;
            inst_word_sel      <= 1'b0;
            new_inst_word      <= '0;
            prog_cntr_int_addr <= '0;

            if (take) begin
                st                 <= S_INTERRUPT;
                stall_fetch        <= 1'b1;
                prog_cntr_load_sel <= (st == S_NORMAL) ? PC_HOLD : PC_LOAD_INT;
                inst_word_sel      <= 1'b1;
                new_inst_word      <= int_word;
                prog_cntr_int_addr <= vec;
                in_service         <= 1'b1;
            end else begin
                case (st)
                    S_NORMAL: begin
                        if (return_req) begin
                            st                 <= S_RETURN;
                            stall_fetch        <= 1'b1;
                            prog_cntr_load_sel <= PC_HOLD;
                            inst_word_sel      <= 1'b1;
                            drain              <= 4'(RET_DRAIN - 1);
                        end else if (halt) begin
                            st                 <= S_HALT;
                            stall_fetch        <= 1'b1;
                            stall_decode       <= 1'b1;
                            prog_cntr_load_sel <= PC_HOLD;
                            inst_word_sel      <= 1'b1;
                        end else if (fetch_stl_req) begin
                            st            <= S_STALL_F;
                            stall_fetch   <= 1'b1;
                            inst_word_sel <= 1'b1;
                        end else if (dec_stl_req) begin
                            st                 <= S_STALL_D;
                            stall_fetch        <= 1'b1;
                            prog_cntr_load_sel <= PC_HOLD;
                            inst_word_sel      <= 1'b1;
                        end
                    end
                    S_HALT: begin
                        st                 <= S_HALT;
                        stall_fetch        <= 1'b1;
                        stall_decode       <= 1'b1;
                        prog_cntr_load_sel <= PC_HOLD;
                        inst_word_sel      <= 1'b1;
                    end
                    S_RETURN: begin
                        if (drain != 4'd0) begin
                            st            <= S_RETURN;
                            stall_fetch   <= 1'b1;
                            inst_word_sel <= 1'b1;
                            drain         <= drain - 4'd1;
                        end else begin
                            in_service <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (default params).
module tb_pipeline_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        return_req, halt, fetch_stl_req, dec_stl_req;
    logic [3:0]  irq, irq_mask;
    logic [13:0] irq_vector_base;
    logic        stall_fetch, stall_decode, inst_word_sel, in_service;
    logic [2:0]  prog_cntr_load_sel, state;
    logic [31:0] new_inst_word;
    logic [13:0] prog_cntr_int_addr;
    logic [3:0]  irq_ack;

    int passed = 0;
    int total  = 0;

    pipeline_hazard_ctrl dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .return_req        (return_req),
        .halt              (halt),
        .fetch_stl_req     (fetch_stl_req),
        .dec_stl_req       (dec_stl_req),
        .irq               (irq),
        .irq_mask          (irq_mask),
        .irq_vector_base   (irq_vector_base),
        .stall_fetch       (stall_fetch),
        .stall_decode      (stall_decode),
        .prog_cntr_load_sel(prog_cntr_load_sel),
        .inst_word_sel     (inst_word_sel),
        .new_inst_word     (new_inst_word),
        .prog_cntr_int_addr(prog_cntr_int_addr),
        .irq_ack           (irq_ack),
        .in_service        (in_service),
        .state             (state)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        reset_n = 1'b0; return_req = 0; halt = 0;
        fetch_stl_req = 0; dec_stl_req = 0;
        irq = 4'b0; irq_mask = 4'b0; irq_vector_base = 14'h0100;
        step(); step();
        reset_n = 1'b1;
        repeat (5) step();
        chk("idle_state", state, 0);
        chk("idle_sel", prog_cntr_load_sel, 3'b001);
        chk("idle_stf", stall_fetch, 0);
        chk("idle_std", stall_decode, 0);
        chk("idle_ack", irq_ack, 0);
        chk("idle_iws", inst_word_sel, 0);

        // two sources rise together: lowest index wins one cycle later
        irq = 4'b0110;
        step();
        chk("lat_state", state, 0);
        step();
        chk("int_state", state, 2);
        chk("int_ack", irq_ack, 4'b0010);
        chk("int_addr", prog_cntr_int_addr, 14'h0104);
        chk("int_word", new_inst_word, 32'h04100042);
        chk("int_sel", prog_cntr_load_sel, 3'b000);
        chk("int_stf", stall_fetch, 1);
        chk("int_insvc", in_service, 1);
        step();
        chk("post_int_state", state, 0);
        chk("post_int_ack", irq_ack, 0);
        irq = 4'b0;
        step(); step();
        chk("nested_block", state, 0);
        chk("nested_ack", irq_ack, 0);

        return_req = 1;
        step();
        return_req = 0;
        chk("ret_state", state, 5);
        chk("ret_sel0", prog_cntr_load_sel, 3'b000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ret_hold", {state, stall_fetch, prog_cntr_load_sel}, {3'd5, 1'b1, 3'b001});
        end
        step();
        chk("ret_done", state, 0);
        chk("ret_insvc", in_service, 0);
        step();
        chk("irq2_state", state, 2);
        chk("irq2_ack", irq_ack, 4'b0100);
        chk("irq2_addr", prog_cntr_int_addr, 14'h0108);
        step();
        return_req = 1;
        step();
        return_req = 0;
        repeat (4) step();
        chk("ret2_insvc", in_service, 0);

        // halt: masked source must not wake it
        halt = 1;
        step();
        halt = 0;
        chk("halt_state", state, 1);
        chk("halt_stalls", {stall_fetch, stall_decode}, 2'b11);
        irq_mask = 4'b1000; irq = 4'b1000;
        repeat (5) step();
        chk("halt_masked", state, 1);
        chk("halt_masked_ack", irq_ack, 0);
        irq_mask = 4'b0;
        step();
        chk("wake_state", state, 2);
        chk("wake_sel", prog_cntr_load_sel, 3'b010);
        chk("wake_addr", prog_cntr_int_addr, 14'h010C);
        chk("wake_word", new_inst_word, 32'h04300042);
        chk("wake_ack", irq_ack, 4'b1000);
        chk("wake_std", stall_decode, 0);
        irq = 4'b0;
        step();
        chk("wake_exit", state, 0);

        // return beats a simultaneous fetch stall
        return_req = 1; fetch_stl_req = 1;
        step();
        return_req = 0; fetch_stl_req = 0;
        chk("ret_vs_stf", state, 5);
        repeat (3) step();
        chk("ret3_last", state, 5);
        step();
        chk("ret3_done", {state, in_service}, {3'd0, 1'b0});

        fetch_stl_req = 1;
        step();
        fetch_stl_req = 0;
        chk("stf_state", state, 3);
        chk("stf_sel", prog_cntr_load_sel, 3'b001);
        chk("stf_stf", stall_fetch, 1);
        step();
        chk("stf_exit", {state, stall_fetch}, {3'd0, 1'b0});

        // reset mid-RETURN discards a pending source
        return_req = 1;
        step();
        return_req = 0;
        irq = 4'b0001;
        step();
        irq = 4'b0;
        chk("rst_pre", state, 5);
        reset_n = 0;
        step();
        chk("rst_state", state, 0);
        chk("rst_stalls", {stall_fetch, stall_decode}, 2'b00);
        chk("rst_sel", prog_cntr_load_sel, 3'b001);
        chk("rst_iws", inst_word_sel, 0);
        chk("rst_word", new_inst_word, 0);
        chk("rst_addr", prog_cntr_int_addr, 0);
        chk("rst_ack_insvc", {irq_ack, in_service}, 5'b0);
        reset_n = 1;
        repeat (3) begin
            step();
            chk("rst_discard", {state, irq_ack}, {3'd0, 4'b0});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
